// File: rtl/mips_pkg.sv
// Shared MIPS-C3 constants: load/store opcodes, default bubble instruction,
// and the memory-stage FSM encoding.
package mips_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SW, OP_SH, OP_SB: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Word-addressed data-memory request/acknowledge bus between the memory
// stage (master) and the data memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/memstore_align.sv
// Byte-lane steering and alignment check for a load/store opcode.
// Loads report all four lanes; the raw word is extracted downstream.
module memstore_align
  import mips_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);

  // lane enables, replicated store data and alignment fault per opcode
  always_comb begin
    be       = 4'b1111;
    wdata    = wd;
    misalign = 1'b0;
    case (op)
      OP_LW, OP_SW: misalign = (addr != 2'b00);
      OP_LH, OP_LHU: misalign = addr[0];
      OP_SH: begin
        misalign = addr[0];
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{wd[15:0]}};
      end
      OP_SB: begin
        be    = 4'b0001 << addr;
        wdata = {4{wd[7:0]}};
      end
      default: begin
        be       = 4'b1111;
        wdata    = wd;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS-C3 memory stage with MEM/WB register: issues one data-memory access
// per load/store and holds the pipeline until the memory acknowledges it.
module mem_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instrm,
  input  logic [31:0]        pcm,
  input  logic [31:0]        aluoutm,
  input  logic [31:0]        writedatam,
  input  logic               validm,
  output logic               stallm,
  mem_stage_if.master        dmem,
  output logic [31:0]        instrw,
  output logic [31:0]        pcw,
  output logic [31:0]        aluoutw,
  output logic [31:0]        readdataw,
  output logic               alignerrw
);

  state_e      state_r, state_s;
  logic        store_s, memop_s, misalign_s;
  logic        issue_s, done_s, fault_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] instr_nx_s, pc_nx_s, alu_nx_s, rd_nx_s;

  memstore_align u_align (
    .op       (instrm[31:26]),
    .addr     (aluoutm[1:0]),
    .wd       (writedatam),
    .be       (be_s),
    .wdata    (wdata_s),
    .misalign (misalign_s)
  );

  // opcode classification of the instruction currently in MEM
  always_comb begin
    store_s = is_store(instrm[31:26]);
    memop_s = validm & (is_load(instrm[31:26]) | store_s);
  end

  // next state, stall and transaction-event decode
  always_comb begin
    state_s = state_r;
    stallm  = 1'b0;
    issue_s = 1'b0;
    done_s  = 1'b0;
    fault_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (memop_s && misalign_s) begin
          fault_s = 1'b1;
        end else if (memop_s) begin
          stallm  = 1'b1;
          issue_s = 1'b1;
          state_s = BUSY;
        end else begin
          stallm  = 1'b0;
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          stallm  = 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // MEM/WB next value: completed access, bubble, faulting access or pass-through
  always_comb begin
    instr_nx_s = NOP_INSTR;
    pc_nx_s    = 32'h0000_0000;
    alu_nx_s   = 32'h0000_0000;
    rd_nx_s    = 32'h0000_0000;
    if (done_s) begin
      instr_nx_s = instrm;
      pc_nx_s    = pcm;
      alu_nx_s   = aluoutm;
      rd_nx_s    = store_s ? 32'h0000_0000 : dmem.dmem_rdata;
    end else if (stallm) begin
      instr_nx_s = NOP_INSTR;
    end else if (fault_s) begin
      pc_nx_s    = pcm;
      alu_nx_s   = aluoutm;
    end else begin
      instr_nx_s = validm ? instrm : NOP_INSTR;
      pc_nx_s    = pcm;
      alu_nx_s   = aluoutm;
    end
  end

  // FSM state and memory request registers; request fields hold while BUSY
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_be    <= 4'b0000;
      dmem.dmem_addr  <= 32'h0000_0000;
      dmem.dmem_wdata <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      if (issue_s) begin
        dmem.dmem_req   <= 1'b1;
        dmem.dmem_we    <= store_s;
        dmem.dmem_be    <= be_s;
        dmem.dmem_addr  <= {aluoutm[31:2], 2'b00};
        dmem.dmem_wdata <= wdata_s;
      end else if (done_s) begin
        dmem.dmem_req   <= 1'b0;
      end
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrw    <= NOP_INSTR;
      pcw       <= 32'h0000_0000;
      aluoutw   <= 32'h0000_0000;
      readdataw <= 32'h0000_0000;
      alignerrw <= 1'b0;
    end else begin
      instrw    <= instr_nx_s;
      pcw       <= pc_nx_s;
      aluoutw   <= alu_nx_s;
      readdataw <= rd_nx_s;
      alignerrw <= fault_s;
    end
  end

endmodule
